// File: rtl/ctrl_frame_injector.sv
// Injects one firmware-built control frame (<=64 B) into the switch header/body FIFOs.
// Latency: first body byte on the edge after send accept; header len-13 edges after accept.
// Backpressure: a full FIFO holds the current byte/header in place; nothing is lost or repeated.
//
// Ports:
//   clk, arst              - sole clock; asynchronous active-high reset
//   h_fifo_din/wren/full   - header FIFO write side (one 128-bit descriptor per frame)
//   b_fifo_din/wren/del/full - body FIFO write side (frame bytes 14..len-1, del on last)
//   iomem_*                - picosoc iomem slave: config/status register and 16-word frame buffer
module ctrl_frame_injector #(
    parameter logic [7:0] CFG_ADDR_HI   = 8'h15,
    parameter logic [7:0] DATA_ADDR_HI  = 8'h05,
    parameter int         HEADER_DWIDTH = 128
) (
    input  logic                     clk,
    input  logic                     arst,
    output logic [HEADER_DWIDTH-1:0] h_fifo_din,
    output logic                     h_fifo_wren,
    input  logic                     h_fifo_full,
    output logic [7:0]               b_fifo_din,
    output logic                     b_fifo_wren,
    output logic                     b_fifo_del,
    input  logic                     b_fifo_full,
    input  logic                     iomem_valid,
    output logic                     iomem_ready,
    input  logic [3:0]               iomem_wstrb,
    input  logic [31:0]              iomem_addr,
    input  logic [31:0]              iomem_wdata,
    output logic [31:0]              iomem_rdata
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BODY   = 2'd1;
    localparam logic [1:0] S_HEADER = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]   r_state;
    logic [5:0]   r_idx;       // byte index of the next body byte
    logic [6:0]   r_flen;      // frame length latched at send
    logic [6:0]   r_len;       // software-visible length register
    logic         r_len_err;
    logic         r_ready;
    logic [31:0]  r_rdata;
    logic [31:0]  r_buf [16];

    logic         w_busy;
    logic         w_req;
    logic         w_sel_cfg;
    logic         w_sel_dat;
    logic [3:0]   w_word;
    logic         w_send_req;
    logic         w_len_ok;
    logic         w_last;
    logic [31:0]  w_cfg_rd;
    logic [511:0] w_flat;
    logic [111:0] w_hdr_bytes;
    logic [127:0] w_hdr;
    logic [7:0]   w_byte;

    assign w_busy    = (r_state != S_IDLE);
    // !r_ready keeps a held request from decoding twice: ready is a one-cycle pulse.
    assign w_req     = iomem_valid && !r_ready;
    assign w_sel_cfg = w_req && (iomem_addr[31:24] == CFG_ADDR_HI);
    assign w_sel_dat = w_req && (iomem_addr[31:24] == DATA_ADDR_HI);
    assign w_word    = iomem_addr[5:2];

    // Send uses the length already in r_len, so a length write in the same access only
    // affects later sends.
    assign w_send_req = w_sel_cfg && iomem_wstrb[3] && iomem_wdata[30] && !w_busy;
    assign w_len_ok   = (r_len >= 7'd15) && (r_len <= 7'd64);

    assign w_cfg_rd = {w_busy, 1'b0, r_len_err, 22'd0, r_len};

    // Flat little-endian view of the buffer: frame byte n sits at w_flat[8n+7:8n].
    for (genvar g = 0; g < 16; g++) begin : g_flat
        assign w_flat[32*g +: 32] = r_buf[g];
    end

    // Header carries bytes 0..13 big-endian (byte 0 in the top byte).
    for (genvar g = 0; g < 14; g++) begin : g_hdr
        assign w_hdr_bytes[111-8*g -: 8] = w_flat[8*g +: 8];
    end

    assign w_hdr  = {1'b0, 4'd0, r_flen, 1'b1, 1'b1, 2'b00, w_hdr_bytes};
    assign w_byte = w_flat[{r_idx, 3'b000} +: 8];
    assign w_last = ({1'b0, r_idx} == (r_flen - 7'd1));

    assign b_fifo_wren = (r_state == S_BODY) && !b_fifo_full;
    assign b_fifo_din  = (r_state == S_BODY) ? w_byte : 8'd0;
    assign b_fifo_del  = b_fifo_wren && w_last;
    assign h_fifo_wren = (r_state == S_HEADER) && !h_fifo_full;
    assign h_fifo_din  = (r_state == S_HEADER) ? w_hdr : '0;

    assign iomem_ready = r_ready;
    assign iomem_rdata = r_rdata;

    // Frame buffer behaves as a RAM: no reset, so a frame survives a mid-send reset.
    // Writes are dropped while busy so the frame in flight cannot change.
    always_ff @(posedge clk) begin
        if (w_sel_dat && !w_busy) begin
            for (int b = 0; b < 4; b++) begin
                if (iomem_wstrb[b]) begin
                    r_buf[w_word][8*b +: 8] <= iomem_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state   <= S_IDLE;
            r_idx     <= 6'd0;
            r_flen    <= 7'd0;
            r_len     <= 7'd60;
            r_len_err <= 1'b0;
            r_ready   <= 1'b0;
            r_rdata   <= 32'd0;
        end else begin
            r_ready <= w_sel_cfg || w_sel_dat;
            if (w_sel_cfg) begin
                r_rdata <= w_cfg_rd;
            end else if (w_sel_dat) begin
                r_rdata <= r_buf[w_word];
            end

            if (w_sel_cfg && iomem_wstrb[0] && !w_busy) begin
                r_len <= iomem_wdata[6:0];
            end
            // Clear first; a rejected send in the same access sets the flag again.
            if (w_sel_cfg && iomem_wstrb[3] && iomem_wdata[29]) begin
                r_len_err <= 1'b0;
            end
            if (w_send_req && !w_len_ok) begin
                r_len_err <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_send_req && w_len_ok) begin
                        r_state <= S_BODY;
                        r_idx   <= 6'd14;
                        r_flen  <= r_len;
                    end
                end
                S_BODY: begin
                    if (b_fifo_wren) begin
                        r_idx <= r_idx + 6'd1;
                        if (w_last) begin
                            r_state <= S_HEADER;
                        end
                    end
                end
                S_HEADER: begin
                    if (h_fifo_wren) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_frame_injector.sv
module tb_ctrl_frame_injector;

    localparam logic [31:0] CFG = 32'h1500_0000;
    localparam logic [31:0] DAT = 32'h0500_0000;

    logic         clk = 1'b0;
    logic         arst;
    logic [127:0] h_fifo_din;
    logic         h_fifo_wren;
    logic         h_fifo_full;
    logic [7:0]   b_fifo_din;
    logic         b_fifo_wren;
    logic         b_fifo_del;
    logic         b_fifo_full;
    logic         iomem_valid;
    logic         iomem_ready;
    logic [3:0]   iomem_wstrb;
    logic [31:0]  iomem_addr;
    logic [31:0]  iomem_wdata;
    logic [31:0]  iomem_rdata;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_acc = 0;
    int first_b_edge = 0;
    int h_edge   = 0;
    int e0       = 0;
    int t_rel    = 0;
    int partial  = 0;

    logic [8:0]   bq [$];
    logic [127:0] hq [$];
    logic [7:0]   fr [64];
    logic [0:19][7:0] pause_hdr;
    logic [31:0]  rd;

    ctrl_frame_injector dut (
        .clk         (clk),
        .arst        (arst),
        .h_fifo_din  (h_fifo_din),
        .h_fifo_wren (h_fifo_wren),
        .h_fifo_full (h_fifo_full),
        .b_fifo_din  (b_fifo_din),
        .b_fifo_wren (b_fifo_wren),
        .b_fifo_del  (b_fifo_del),
        .b_fifo_full (b_fifo_full),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Strobes sampled at negedge; the write lands on the following posedge (cyc+1).
    always @(negedge clk) begin
        if (b_fifo_wren) begin
            if (bq.size() == 0) first_b_edge = cyc + 1;
            bq.push_back({b_fifo_del, b_fifo_din});
        end
        if (h_fifo_wren) begin
            hq.push_back(h_fifo_din);
            h_edge = cyc + 1;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 with the bus idle again.
    task automatic bus(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                       output logic [31:0] r);
        int n;
        iomem_valid = 1'b1;
        iomem_addr  = a;
        iomem_wstrb = s;
        iomem_wdata = d;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!iomem_ready && n < 20);
        last_acc = cyc;
        chk("bus_ack", {127'd0, iomem_ready}, 128'd1);
        r = iomem_rdata;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'd0;
        @(posedge clk); #1;
        chk("ready_pulse", {127'd0, iomem_ready}, 128'd0);
    endtask

    task automatic wait_idle();
        logic [31:0] r;
        int n;
        n = 0;
        do begin
            bus(CFG, 4'd0, 32'd0, r);
            n++;
        end while (r[31] && n < 200);
        chk("idle_reached", {127'd0, r[31]}, 128'd0);
    endtask

    function automatic logic [127:0] hdr_exp(input int len);
        logic [127:0] h;
        h = '0;
        h[126:116] = 11'(len);
        h[115] = 1'b1;
        h[114] = 1'b1;
        for (int k = 0; k < 14; k++) h[111-8*k -: 8] = fr[k];
        return h;
    endfunction

    task automatic check_frame(input int len, input int base);
        logic [8:0] obs;
        chk($sformatf("body_count_len%0d", len), 128'(bq.size()), 128'(base + len - 14));
        for (int n = 14; n < len; n++) begin
            obs = (base + n - 14 < bq.size()) ? bq[base + n - 14] : 9'bx;
            chk($sformatf("body_byte%0d_len%0d", n, len), {119'd0, obs},
                {119'd0, (n == len - 1), fr[n]});
        end
        chk($sformatf("hdr_count_len%0d", len), 128'(hq.size()), 128'd1);
        if (hq.size() > 0) chk($sformatf("hdr_word_len%0d", len), hq[0], hdr_exp(len));
    endtask

    initial begin
        arst = 1'b1;
        h_fifo_full = 1'b0;
        b_fifo_full = 1'b0;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'd0;
        iomem_addr  = 32'd0;
        iomem_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {127'd0, iomem_ready}, 128'd0);
        chk("rst_rdata", 128'(iomem_rdata), 128'd0);
        chk("rst_hwren", {127'd0, h_fifo_wren}, 128'd0);
        chk("rst_bwren", {127'd0, b_fifo_wren}, 128'd0);
        chk("rst_bdel", {127'd0, b_fifo_del}, 128'd0);
        chk("rst_hdin", h_fifo_din, 128'd0);
        chk("rst_bdin", 128'(b_fifo_din), 128'd0);
        arst = 1'b0;
        @(posedge clk); #1;
        bus(CFG, 4'd0, 32'd0, rd);
        chk("cfg_reset", 128'(rd), 128'h3C);

        // PAUSE frame: dst 01:80:C2:00:00:01, src 00:11:22:33:44:55, 8808, opcode 0001, quanta 00FF
        pause_hdr = {8'h01, 8'h80, 8'hC2, 8'h00, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33,
                     8'h44, 8'h55, 8'h88, 8'h08, 8'h00, 8'h01, 8'h00, 8'hFF, 8'h00, 8'h00};
        for (int i = 0; i < 64; i++) fr[i] = (i < 20) ? pause_hdr[i] : 8'(i * 7 + 3);
        for (int w = 0; w < 16; w++)
            bus(DAT | 32'(w << 2), 4'hF, {fr[4*w+3], fr[4*w+2], fr[4*w+1], fr[4*w]}, rd);
        // Single-lane write touches only byte 60.
        bus(DAT | 32'(15 << 2), 4'b0001, 32'hFFFF_FFFF, rd);
        fr[60] = 8'hFF;
        bus(DAT | 32'(15 << 2), 4'd0, 32'd0, rd);
        chk("data_rd_w15", 128'(rd), 128'({fr[63], fr[62], fr[61], fr[60]}));
        bus(DAT | 32'(3 << 2), 4'd0, 32'd0, rd);
        chk("data_rd_w3", 128'(rd), 128'({fr[15], fr[14], fr[13], fr[12]}));

        // Normal send of len 60, with writes and a second send issued while busy.
        bq.delete(); hq.delete();
        bus(CFG, 4'b1000, 32'h4000_0000, rd);
        e0 = last_acc;
        bus(CFG, 4'd0, 32'd0, rd);
        chk("cfg_busy", 128'(rd), 128'h8000_003C);
        bus(DAT | 32'(14 << 2), 4'hF, 32'hDEAD_BEEF, rd);
        bus(CFG, 4'b1001, 32'h4000_0014, rd);
        wait_idle();
        check_frame(60, 0);
        if (hq.size() > 0) chk("hdr_dst_mac", 128'(hq[0][111:64]), 128'h0180_C200_0001);
        chk("first_body_edge", 128'(first_b_edge - e0), 128'd1);
        chk("header_edge", 128'(h_edge - e0), 128'd47);
        bus(CFG, 4'd0, 32'd0, rd);
        chk("cfg_len_kept", 128'(rd), 128'h3C);
        bus(DAT | 32'(14 << 2), 4'd0, 32'd0, rd);
        chk("buf_kept_w14", 128'(rd), 128'({fr[59], fr[58], fr[57], fr[56]}));

        // Backpressure: body FIFO toggles full, header FIFO held full until body done.
        bq.delete(); hq.delete();
        h_fifo_full = 1'b1;
        bus(CFG, 4'b1000, 32'h4000_0000, rd);
        for (int c = 0; c < 110; c++) begin
            b_fifo_full = ~b_fifo_full;
            @(posedge clk); #1;
        end
        chk("bp_body_done", 128'(bq.size()), 128'd46);
        chk("bp_hdr_held", 128'(hq.size()), 128'd0);
        b_fifo_full = 1'b0;
        h_fifo_full = 1'b0;
        t_rel = cyc;
        wait_idle();
        chk("bp_hdr_edge", 128'(h_edge - t_rel), 128'd1);
        check_frame(60, 0);

        // len 64 boundary
        bq.delete(); hq.delete();
        bus(CFG, 4'b0001, 32'd64, rd);
        bus(CFG, 4'b1000, 32'h4000_0000, rd);
        wait_idle();
        check_frame(64, 0);

        // len 15 boundary
        bq.delete(); hq.delete();
        bus(CFG, 4'b0001, 32'd15, rd);
        bus(CFG, 4'b1000, 32'h4000_0000, rd);
        wait_idle();
        check_frame(15, 0);

        // len 14 rejected
        bq.delete(); hq.delete();
        bus(CFG, 4'b0001, 32'd14, rd);
        bus(CFG, 4'b1000, 32'h4000_0000, rd);
        repeat (5) @(posedge clk);
        #1;
        bus(CFG, 4'd0, 32'd0, rd);
        chk("len14_err", 128'(rd), 128'h2000_000E);
        chk("len14_no_body", 128'(bq.size()), 128'd0);
        chk("len14_no_hdr", 128'(hq.size()), 128'd0);
        bus(CFG, 4'b1000, 32'h2000_0000, rd);
        bus(CFG, 4'd0, 32'd0, rd);
        chk("len_err_clear", 128'(rd), 128'h0000_000E);

        // len 65 rejected; clear+send in one write leaves the error set
        bus(CFG, 4'b0001, 32'd65, rd);
        bus(CFG, 4'b1000, 32'h6000_0000, rd);
        repeat (5) @(posedge clk);
        #1;
        bus(CFG, 4'd0, 32'd0, rd);
        chk("len65_err", 128'(rd), 128'h2000_0041);
        chk("len65_no_body", 128'(bq.size()), 128'd0);
        chk("len65_no_hdr", 128'(hq.size()), 128'd0);
        bus(CFG, 4'b1001, 32'h2000_003C, rd);
        bus(CFG, 4'd0, 32'd0, rd);
        chk("cfg_restore", 128'(rd), 128'h3C);

        // Reset in the middle of the body; bytes 14..22 already written (edges E1..E9).
        bq.delete(); hq.delete();
        bus(CFG, 4'b1000, 32'h4000_0000, rd);
        repeat (8) @(posedge clk);
        #1;
        arst = 1'b1;
        #1;
        chk("midrst_bwren", {127'd0, b_fifo_wren}, 128'd0);
        @(posedge clk); #1;
        arst = 1'b0;
        @(posedge clk); #1;
        partial = bq.size();
        chk("midrst_partial", 128'(partial), 128'd9);
        for (int j = 0; j < 9; j++)
            if (j < bq.size()) chk($sformatf("midrst_byte%0d", j), {119'd0, bq[j]}, {119'd0, 1'b0, fr[14+j]});
        chk("midrst_no_hdr", 128'(hq.size()), 128'd0);
        bus(CFG, 4'd0, 32'd0, rd);
        chk("midrst_cfg", 128'(rd), 128'h3C);
        bus(CFG, 4'b1000, 32'h4000_0000, rd);
        wait_idle();
        check_frame(60, 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
